// File: rtl/b3_serial_incrementer.sv
// Serial base-3 incrementer: one half-adder digit cell is time-shared across an
// N-digit base-3 register, walking from the LSB towards the MSB one digit per
// cycle and stopping as soon as the carry dies.
//
// Ports:
//   clock       system clock, rising edge
//   reset_      synchronous active-low reset
//   load        load request (IDLE only); wins over start
//   load_value  digits to load, digit i = load_value[2i+1:2i]; 2'b11 loads as 0
//   start       begin one increment (IDLE only)
//   inc         addend (0/1), sampled with start
//   value       stored number, digit 0 = LSB
//   busy        high while digits are being updated
//   done        one-cycle pulse after the last digit update
//   overflow    carry out of the top digit on the last increment (sticky)
//   err         last load carried an invalid digit (sticky)
module b3_serial_incrementer #(
  parameter int unsigned N = 4
) (
  input  logic           clock,
  input  logic           reset_,
  input  logic           load,
  input  logic [2*N-1:0] load_value,
  input  logic           start,
  input  logic           inc,
  output logic [2*N-1:0] value,
  output logic           busy,
  output logic           done,
  output logic           overflow,
  output logic           err
);

  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

  typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

  state_e          state_q, state_d;
  logic [2*N-1:0]  value_q, value_d;
  logic [IdxW-1:0] index_q, index_d;
  logic            carry_q, carry_d;
  logic            overflow_q, overflow_d;
  logic            err_q, err_d;

  logic [1:0]      cur_digit;
  logic [1:0]      cell_sum;
  logic            cell_cout;
  logic [2*N-1:0]  load_clean;
  logic            load_bad;

  // Shared digit cell: select the digit under the cursor and add the carry.
  always_comb begin
    cur_digit = 2'b00;
    for (int unsigned i = 0; i < N; i++) begin
      if (index_q == IdxW'(i)) cur_digit = value_q[2*i +: 2];
    end
    cell_cout = (cur_digit == 2'd2) && carry_q;
    cell_sum  = cur_digit;
    if (carry_q) begin
      unique case (cur_digit)
        2'd0:    cell_sum = 2'd1;
        2'd1:    cell_sum = 2'd2;
        default: cell_sum = 2'd0;
      endcase
    end
  end

  // Invalid 11 digits are never stored; they are flagged and replaced with 0.
  always_comb begin
    load_clean = load_value;
    load_bad   = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (load_value[2*i +: 2] == 2'b11) begin
        load_clean[2*i +: 2] = 2'b00;
        load_bad             = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    value_d    = value_q;
    index_d    = index_q;
    carry_d    = carry_q;
    overflow_d = overflow_q;
    err_d      = err_q;
    unique case (state_q)
      StIdle: begin
        if (load) begin
          value_d    = load_clean;
          err_d      = load_bad;
          overflow_d = 1'b0;
        end else if (start) begin
          carry_d    = inc;
          index_d    = '0;
          overflow_d = 1'b0;
          state_d    = StAdd;
        end
      end
      StAdd: begin
        for (int unsigned i = 0; i < N; i++) begin
          if (index_q == IdxW'(i)) value_d[2*i +: 2] = cell_sum;
        end
        carry_d = cell_cout;
        if (!cell_cout || index_q == LastIdx) begin
          overflow_d = cell_cout;
          state_d    = StDone;
        end else begin
          index_d = index_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_) begin
      state_q    <= StIdle;
      value_q    <= '0;
      index_q    <= '0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      value_q    <= value_d;
      index_q    <= index_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
      err_q      <= err_d;
    end
  end

  assign value    = value_q;
  assign busy     = (state_q == StAdd);
  assign done     = (state_q == StDone);
  assign overflow = overflow_q;
  assign err      = err_q;

endmodule

// File: tb/tb_b3_serial_incrementer.sv
module tb_b3_serial_incrementer;

  localparam int N = 4;
  localparam int W = 2 * N;

  logic         clock = 1'b0;
  logic         reset_;
  logic         load;
  logic [W-1:0] load_value;
  logic         start;
  logic         inc;
  logic [W-1:0] value;
  logic         busy;
  logic         done;
  logic         overflow;
  logic         err;

  b3_serial_incrementer #(.N(N)) dut (
    .clock      (clock),
    .reset_     (reset_),
    .load       (load),
    .load_value (load_value),
    .start      (start),
    .inc        (inc),
    .value      (value),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow),
    .err        (err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [W-1:0] val;
    logic         ovf;
    logic         er;
    int           cycles;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   busy_cnt = 0;

  // Reference model: the stored number as a plain integer.
  int   m_val = 0;
  logic m_err = 1'b0;
  logic m_ovf = 1'b0;

  function automatic int pow3(int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 3;
    return r;
  endfunction

  function automatic logic [W-1:0] enc(int n);
    logic [W-1:0] r = '0;
    int x = n;
    for (int i = 0; i < N; i++) begin
      r[2*i +: 2] = 2'(x % 3);
      x = x / 3;
    end
    return r;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard monitor: compare on every done pulse.
  always @(negedge clock) begin
    if (reset_ !== 1'b1) begin
      busy_cnt = 0;
    end else begin
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("done_value", 32'(value), 32'(e.val));
          check("done_overflow", 32'(overflow), 32'(e.ovf));
          check("done_err", 32'(err), 32'(e.er));
          check("add_cycles", 32'(busy_cnt), 32'(e.cycles));
        end
        busy_cnt = 0;
      end
    end
  end

  // Load (optionally together with start, which must be dropped).
  task automatic do_load(logic [W-1:0] lv, logic with_start);
    int d;
    load       = 1'b1;
    load_value = lv;
    start      = with_start;
    inc        = 1'b1;
    step();
    load  = 1'b0;
    start = 1'b0;
    m_err = 1'b0;
    m_val = 0;
    for (int i = N - 1; i >= 0; i--) begin
      d = int'(lv[2*i +: 2]);
      if (d == 3) begin
        m_err = 1'b1;
        d = 0;
      end
      m_val = m_val * 3 + d;
    end
    m_ovf = 1'b0;
    check("load_value", 32'(value), 32'(enc(m_val)));
    check("load_err", 32'(err), 32'(m_err));
    check("load_overflow", 32'(overflow), 32'(m_ovf));
    check("load_busy", 32'(busy), 32'd0);
  endtask

  // mode 0: plain; 1: pulse start+load during ADD; 2: reset in 2nd ADD cycle;
  // 3: present start during DONE.
  task automatic do_start(logic i, int mode);
    int   t, x, cyc, nv;
    logic ov;
    bit   seen;
    t = 0;
    x = m_val;
    while (i && t < N && (x % 3) == 2) begin
      t++;
      x = x / 3;
    end
    cyc = i ? ((t + 1 > N) ? N : t + 1) : 1;
    nv  = m_val + int'(i);
    ov  = (nv >= pow3(N));
    nv  = nv % pow3(N);
    sb.push_back('{val: enc(nv), ovf: ov, er: m_err, cycles: cyc});
    m_val = nv;
    m_ovf = ov;

    start = 1'b1;
    inc   = i;
    step();
    start = 1'b0;
    inc   = 1'($urandom);
    if (mode == 1) begin
      start      = 1'b1;
      load       = 1'b1;
      load_value = W'($urandom);
      step();
      start = 1'b0;
      load  = 1'b0;
    end
    if (mode == 2) begin
      step();
      reset_ = 1'b0;
      step();
      reset_ = 1'b1;
      sb.delete();
      m_val = 0;
      m_err = 1'b0;
      m_ovf = 1'b0;
      check("midreset_value", 32'(value), 32'd0);
      check("midreset_busy", 32'(busy), 32'd0);
      check("midreset_done", 32'(done), 32'd0);
      check("midreset_ovf", 32'(overflow), 32'd0);
      repeat (3) step();
      return;
    end
    seen = 1'b0;
    for (int k = 0; k < 3 * N + 4; k++) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    if (!seen) begin
      check("done_timeout", 32'd0, 32'd1);
      return;
    end
    if (mode == 3) begin
      start = 1'b1;
      inc   = 1'b1;
    end
    step();
    start = 1'b0;
    check("idle_after_done", 32'(busy), 32'd0);
    check("ovf_hold", 32'(overflow), 32'(m_ovf));
  endtask

  initial begin
    reset_     = 1'b0;
    load       = 1'b0;
    load_value = '0;
    start      = 1'b1;
    inc        = 1'b1;
    step();
    step();
    check("rst_value", 32'(value), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    start  = 1'b0;
    reset_ = 1'b1;
    step();

    // Directed cases (values written in base-3).
    do_load(enc(15), 1'b0);  // 0120
    do_start(1'b1, 0);       // -> 0121, 1 ADD cycle
    do_load(enc(26), 1'b0);  // 0222
    do_start(1'b1, 0);       // -> 1000, 4 ADD cycles
    do_load(enc(80), 1'b0);  // 2222
    do_start(1'b1, 0);       // -> 0000, overflow
    do_start(1'b0, 0);       // overflow clears
    do_load(8'b11_01_10_00, 1'b0);  // -> 0120, err
    do_load(enc(40), 1'b1);  // load wins over start
    do_load(enc(8), 1'b0);   // 0022
    do_start(1'b1, 1);       // disturbed -> 0100
    do_load(enc(8), 1'b0);
    do_start(1'b1, 2);       // reset during 2nd ADD cycle
    do_load(enc(17), 1'b0);
    do_start(1'b1, 3);       // start in DONE ignored

    for (int it = 0; it < 200; it++) begin
      int r;
      r = int'($urandom_range(0, 11));
      if (r < 2)       do_load(W'($urandom), 1'b0);
      else if (r < 4)  do_load(enc(int'($urandom_range(0, pow3(N) - 1))), 1'b0);
      else if (r == 4) do_load(enc(pow3(N) - 1 - int'($urandom_range(0, 1))), 1'b0);
      else if (r == 5) do_load(W'($urandom), 1'b1);
      else             do_start(1'($urandom), (r == 6) ? 1 : ((r == 7) ? 3 : 0));
    end

    repeat (4) step();
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
